// File: rtl/riscv_defines.sv
// Shared definitions for the IRQ source controller.
// Register map and interrupt ID type.
package riscv_defines;

  localparam logic [1:0] IRQ_REG_MASK = 2'd0;
  localparam logic [1:0] IRQ_REG_PSET = 2'd1;
  localparam logic [1:0] IRQ_REG_PCLR = 2'd2;
  localparam logic [1:0] IRQ_REG_SEC  = 2'd3;

  typedef logic [4:0] irq_id_t;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Priority encoder: index of the highest set bit.
// Bit 31 has the highest priority.
module riscv_irq_prio_enc
  import riscv_defines::*;
(
  input  logic [31:0] req_i,
  output logic        valid_o,
  output irq_id_t     idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = 0; i < 32; i++) begin
      if (req_i[i]) idx_o = irq_id_t'(i);
    end
  end

endmodule

// File: rtl/riscv_irq_source_ctrl.sv
// Interrupt source side of the core's level-triggered IRQ port:
// pending latch, mask, priority select and registered outputs.
module riscv_irq_source_ctrl
  import riscv_defines::*;
#(
  parameter int          NUM_IRQ    = 32,
  parameter logic [31:0] RST_MASK   = '0,
  parameter logic [31:0] RST_SECURE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] event_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  output logic               irq_sec_o,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_ack_id_i
);

  localparam logic [31:0] VLD = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                              : 32'((64'd1 << NUM_IRQ) - 64'd1);

  logic [31:0] pend_q, pend_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] sec_q, sec_d;
  logic        irq_q, irq_d;
  irq_id_t     id_q, id_d;
  logic        seco_q, seco_d;

  logic [31:0] ev;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] ack_vec;
  logic [31:0] active;
  logic        enc_vld;
  irq_id_t     enc_idx;

  always_comb begin
    ev = '0;
    ev[NUM_IRQ-1:0] = event_i;
    set_vec = '0;
    clr_vec = '0;
    mask_d  = mask_q;
    sec_d   = sec_q;
    if (cfg_we_i) begin
      unique case (1'b1)
        cfg_addr_i == IRQ_REG_MASK: mask_d  = cfg_wdata_i & VLD;
        cfg_addr_i == IRQ_REG_PSET: set_vec = cfg_wdata_i & VLD;
        cfg_addr_i == IRQ_REG_PCLR: clr_vec = cfg_wdata_i & VLD;
        cfg_addr_i == IRQ_REG_SEC:  sec_d   = cfg_wdata_i & VLD;
      endcase
    end
    // Out-of-range ack IDs never decode, so they change nothing.
    ack_vec = '0;
    if (irq_ack_i && int'(irq_ack_id_i) < NUM_IRQ)
      ack_vec[irq_ack_id_i] = 1'b1;
    pend_d = ev | set_vec | (pend_q & ~clr_vec & ~ack_vec);
    active = pend_d & mask_d;
  end

  riscv_irq_prio_enc u_enc (
    .req_i   (active),
    .valid_o (enc_vld),
    .idx_o   (enc_idx)
  );

  always_comb begin
    irq_d  = enc_vld;
    id_d   = enc_vld ? enc_idx : id_q;
    seco_d = enc_vld & sec_d[enc_idx];
  end

  always_comb begin
    cfg_rdata_o = '0;
    unique case (1'b1)
      cfg_addr_i == IRQ_REG_MASK: cfg_rdata_o = mask_q;
      cfg_addr_i == IRQ_REG_PSET: cfg_rdata_o = pend_q;
      cfg_addr_i == IRQ_REG_PCLR: cfg_rdata_o = pend_q;
      cfg_addr_i == IRQ_REG_SEC:  cfg_rdata_o = sec_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      mask_q <= RST_MASK & VLD;
      sec_q  <= RST_SECURE & VLD;
      irq_q  <= 1'b0;
      id_q   <= '0;
      seco_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      sec_q  <= sec_d;
      irq_q  <= irq_d;
      id_q   <= id_d;
      seco_q <= seco_d;
    end
  end

  assign irq_o     = irq_q;
  assign irq_id_o  = id_q;
  assign irq_sec_o = seco_q;

endmodule
